// File: rtl/pe_mac_pkg.sv
// Shared types and default widths for the PE MAC sequencer slice.
package pe_mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

  localparam int DEF_INPUT_WIDTH   = 8;
  localparam int DEF_PRODUCT_WIDTH = 20;
  localparam int DEF_ACC_WIDTH     = 32;
  localparam int DEF_ADDR_WIDTH    = 10;
  localparam int DEF_MAX_LEN       = 256;

  // A full-length run of worst-case products must fit the accumulator.
  function automatic bit widths_ok(input int product_width, input int max_len, input int acc_width);
    return (product_width + $clog2(max_len)) <= acc_width;
  endfunction

endpackage

// File: rtl/pe_mac_accum.sv
// Valid pipeline tracking buffer/PE latency, operand gating and the
// sign-extending dot-product accumulator.
module pe_mac_accum
  import pe_mac_pkg::*;
#(
  parameter int INPUT_WIDTH   = DEF_INPUT_WIDTH,
  parameter int PRODUCT_WIDTH = DEF_PRODUCT_WIDTH,
  parameter int ACC_WIDTH     = DEF_ACC_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     rd_en,
  input  logic [INPUT_WIDTH-1:0]   ifm_data,
  input  logic [INPUT_WIDTH-1:0]   wgt_data,
  input  logic [PRODUCT_WIDTH-1:0] pe_product,
  output logic [INPUT_WIDTH-1:0]   pe_ifm,
  output logic [INPUT_WIDTH-1:0]   pe_wgt,
  output logic                     v1,
  output logic [ACC_WIDTH-1:0]     acc_nxt
);

  logic                 v1_r;
  logic                 v2_r;
  logic [ACC_WIDTH-1:0] acc_r;
  logic [ACC_WIDTH-1:0] product_ext_s;

  assign v1            = v1_r;
  assign product_ext_s = {{(ACC_WIDTH-PRODUCT_WIDTH){pe_product[PRODUCT_WIDTH-1]}}, pe_product};

  // Operands are forced to zero whenever the buffers hold no fresh data.
  always_comb begin
    pe_ifm = {INPUT_WIDTH{1'b0}};
    pe_wgt = {INPUT_WIDTH{1'b0}};
    if (v1_r) begin
      pe_ifm = ifm_data;
      pe_wgt = wgt_data;
    end else begin
      pe_ifm = {INPUT_WIDTH{1'b0}};
      pe_wgt = {INPUT_WIDTH{1'b0}};
    end
  end

  // Next accumulator value; exposed so the top can capture the final sum on the landing edge.
  always_comb begin
    acc_nxt = acc_r;
    if (clr) begin
      acc_nxt = {ACC_WIDTH{1'b0}};
    end else if (v2_r) begin
      acc_nxt = acc_r + product_ext_s;
    end else begin
      acc_nxt = acc_r;
    end
  end

  // Valid pipeline and accumulator state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_r  <= 1'b0;
      v2_r  <= 1'b0;
      acc_r <= {ACC_WIDTH{1'b0}};
    end else begin
      v1_r  <= rd_en;
      v2_r  <= v1_r;
      acc_r <= acc_nxt;
    end
  end

endmodule

// File: rtl/pe_mac_sequencer.sv
// Streams a configured run of IFM/weight pairs into one PE and returns the
// accumulated signed dot product on a valid/ready port.
module pe_mac_sequencer
  import pe_mac_pkg::*;
#(
  parameter  int INPUT_WIDTH   = DEF_INPUT_WIDTH,
  parameter  int PRODUCT_WIDTH = DEF_PRODUCT_WIDTH,
  parameter  int ACC_WIDTH     = DEF_ACC_WIDTH,
  parameter  int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter  int MAX_LEN       = DEF_MAX_LEN,
  localparam int LEN_W         = $clog2(MAX_LEN + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [LEN_W-1:0]         cfg_len,
  input  logic [ADDR_WIDTH-1:0]    cfg_ifm_base,
  input  logic [ADDR_WIDTH-1:0]    cfg_wgt_base,
  output logic                     busy,
  output logic                     rd_en,
  output logic [ADDR_WIDTH-1:0]    ifm_addr,
  output logic [ADDR_WIDTH-1:0]    wgt_addr,
  input  logic [INPUT_WIDTH-1:0]   ifm_data,
  input  logic [INPUT_WIDTH-1:0]   wgt_data,
  output logic [INPUT_WIDTH-1:0]   pe_ifm,
  output logic [INPUT_WIDTH-1:0]   pe_wgt,
  input  logic [PRODUCT_WIDTH-1:0] pe_product,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_WIDTH-1:0]     out_data
);

  if (!widths_ok(PRODUCT_WIDTH, MAX_LEN, ACC_WIDTH)) begin : g_width_err
    $error("pe_mac_sequencer: PRODUCT_WIDTH + clog2(MAX_LEN) exceeds ACC_WIDTH");
  end

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [LEN_W-1:0]       len_r;
  logic [LEN_W-1:0]       idx_r;
  logic [ADDR_WIDTH-1:0]  ifm_addr_r;
  logic [ADDR_WIDTH-1:0]  wgt_addr_r;
  logic                   rd_en_r;
  logic                   busy_r;
  logic                   out_valid_r;
  logic [ACC_WIDTH-1:0]   out_data_r;
  logic                   start_ok_s;
  logic                   last_s;
  logic                   v1_s;
  logic [ACC_WIDTH-1:0]   acc_nxt_s;

  assign start_ok_s = (state_r == IDLE) && start;
  assign last_s     = ((idx_r + LEN_W'(1)) == len_r);

  assign busy      = busy_r;
  assign rd_en     = rd_en_r;
  assign ifm_addr  = ifm_addr_r;
  assign wgt_addr  = wgt_addr_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;

  pe_mac_accum #(
    .INPUT_WIDTH   (INPUT_WIDTH),
    .PRODUCT_WIDTH (PRODUCT_WIDTH),
    .ACC_WIDTH     (ACC_WIDTH)
  ) u_accum (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (start_ok_s),
    .rd_en      (rd_en_r),
    .ifm_data   (ifm_data),
    .wgt_data   (wgt_data),
    .pe_product (pe_product),
    .pe_ifm     (pe_ifm),
    .pe_wgt     (pe_wgt),
    .v1         (v1_s),
    .acc_nxt    (acc_nxt_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state; DRAIN leaves once v1 is clear, as the final add lands on that same edge.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (cfg_len == {LEN_W{1'b0}}) begin
            state_nxt_s = OUT;
          end else begin
            state_nxt_s = ISSUE;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        if (last_s) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = ISSUE;
        end
      end
      DRAIN: begin
        if (!v1_s) begin
          state_nxt_s = OUT;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      OUT: begin
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = OUT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Run length and issue index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_r <= {LEN_W{1'b0}};
      idx_r <= {LEN_W{1'b0}};
    end else if (start_ok_s) begin
      len_r <= cfg_len;
      idx_r <= {LEN_W{1'b0}};
    end else if (state_r == ISSUE) begin
      idx_r <= idx_r + LEN_W'(1);
    end
  end

  // Registered outputs derived from the upcoming state; addresses wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r      <= 1'b0;
      rd_en_r     <= 1'b0;
      out_valid_r <= 1'b0;
      ifm_addr_r  <= {ADDR_WIDTH{1'b0}};
      wgt_addr_r  <= {ADDR_WIDTH{1'b0}};
      out_data_r  <= {ACC_WIDTH{1'b0}};
    end else begin
      busy_r      <= (state_nxt_s != IDLE);
      rd_en_r     <= (state_nxt_s == ISSUE);
      out_valid_r <= (state_nxt_s == OUT);
      if (state_nxt_s == ISSUE) begin
        if (state_r == IDLE) begin
          ifm_addr_r <= cfg_ifm_base;
          wgt_addr_r <= cfg_wgt_base;
        end else begin
          ifm_addr_r <= ifm_addr_r + ADDR_WIDTH'(1);
          wgt_addr_r <= wgt_addr_r + ADDR_WIDTH'(1);
        end
      end else begin
        ifm_addr_r <= {ADDR_WIDTH{1'b0}};
        wgt_addr_r <= {ADDR_WIDTH{1'b0}};
      end
      if (state_nxt_s != OUT) begin
        out_data_r <= {ACC_WIDTH{1'b0}};
      end else if (state_r != OUT) begin
        out_data_r <= acc_nxt_s;
      end
    end
  end

endmodule

// File: tb/tb_pe_mac_sequencer.sv
// Directed bench for pe_mac_sequencer with behavioural operand buffers and PE.
module tb_pe_mac_sequencer;

  localparam int IW  = 8;
  localparam int PW  = 20;
  localparam int AW  = 32;
  localparam int ADW = 10;
  localparam int LW  = 9;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           start = 1'b0;
  logic [LW-1:0]  cfg_len = '0;
  logic [ADW-1:0] cfg_ifm_base = '0;
  logic [ADW-1:0] cfg_wgt_base = '0;
  logic           busy;
  logic           rd_en;
  logic [ADW-1:0] ifm_addr;
  logic [ADW-1:0] wgt_addr;
  logic [IW-1:0]  ifm_data = '0;
  logic [IW-1:0]  wgt_data = '0;
  logic [IW-1:0]  pe_ifm;
  logic [IW-1:0]  pe_wgt;
  logic [PW-1:0]  pe_product;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [AW-1:0]  out_data;

  logic [IW-1:0]        ifm_mem [0:1023];
  logic [IW-1:0]        wgt_mem [0:1023];
  logic signed [15:0]   prod_s;
  int                   checks = 0;
  int                   failures = 0;
  int                   n;

  always #5 clk = ~clk;

  pe_mac_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .cfg_len      (cfg_len),
    .cfg_ifm_base (cfg_ifm_base),
    .cfg_wgt_base (cfg_wgt_base),
    .busy         (busy),
    .rd_en        (rd_en),
    .ifm_addr     (ifm_addr),
    .wgt_addr     (wgt_addr),
    .ifm_data     (ifm_data),
    .wgt_data     (wgt_data),
    .pe_ifm       (pe_ifm),
    .pe_wgt       (pe_wgt),
    .pe_product   (pe_product),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data)
  );

  // Synchronous-read operand buffers.
  always @(posedge clk) begin
    if (rd_en) begin
      ifm_data <= ifm_mem[ifm_addr];
      wgt_data <= wgt_mem[wgt_addr];
    end
  end

  // PE multiplier with one registered stage.
  assign prod_s = $signed(pe_ifm) * $signed(pe_wgt);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pe_product <= '0;
    else        pe_product <= {{4{prod_s[15]}}, prod_s};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, 64'({busy, rd_en, ifm_addr, wgt_addr, pe_ifm, pe_wgt, out_valid}), 64'sd0);
    chk({tag, "_data"}, 64'(out_data), 64'sd0);
  endtask

  task automatic wait_valid(input int max_cycles, output int cnt);
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < max_cycles) begin
      tick();
      cnt++;
    end
  endtask

  task automatic fill(input logic [IW-1:0] iv, input logic [IW-1:0] wv);
    for (int i = 0; i < 1024; i++) begin
      ifm_mem[i] = iv;
      wgt_mem[i] = wv;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    fill(8'h00, 8'h00);
    #2 rst_n = 1'b0;
    #1 chk_zero("reset");
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_rd_busy", 64'({rd_en, busy}), 64'sd0);
    end

    // N=3 basic dot product: 4 - 10 - 18 = -24
    ifm_mem[0] = 8'd1;  ifm_mem[1] = 8'hFE; ifm_mem[2] = 8'd3;
    wgt_mem[100] = 8'd4; wgt_mem[101] = 8'd5; wgt_mem[102] = 8'hFA;
    cfg_len = 9'd3; cfg_ifm_base = 10'd0; cfg_wgt_base = 10'd100; start = 1'b1;
    tick(); start = 1'b0;
    chk("n3_c1", 64'({busy, rd_en, ifm_addr, wgt_addr}), 64'({1'b1, 1'b1, 10'd0, 10'd100}));
    tick();
    chk("n3_c2", 64'({rd_en, ifm_addr, wgt_addr}), 64'({1'b1, 10'd1, 10'd101}));
    chk("n3_pe", 64'({pe_ifm, pe_wgt}), 64'({8'd1, 8'd4}));
    tick();
    chk("n3_c3", 64'({rd_en, ifm_addr, wgt_addr}), 64'({1'b1, 10'd2, 10'd102}));
    tick();
    chk("n3_c4", 64'({rd_en, out_valid}), 64'sd0);
    tick();
    chk("n3_c5_valid", 64'(out_valid), 64'sd0);
    tick();
    chk("n3_c6_valid", 64'({busy, out_valid}), 64'sd3);
    chk("n3_c6_data", 64'($signed(out_data)), -64'sd24);
    out_ready = 1'b1;
    tick(); out_ready = 1'b0;
    chk("n3_after_hs", 64'({busy, out_valid}), 64'sd0);

    // Full-length run with wrap and backpressure: 256 * 16384
    fill(8'h80, 8'h80);
    cfg_len = 9'd256; cfg_ifm_base = 10'd1020; cfg_wgt_base = 10'd3; start = 1'b1;
    tick(); start = 1'b0;
    chk("max_addr0", 64'(ifm_addr), 64'sd1020);
    repeat (4) tick();
    chk("max_wrap", 64'({ifm_addr, wgt_addr}), 64'({10'd0, 10'd7}));
    wait_valid(400, n);
    chk("max_valid", 64'(out_valid), 64'sd1);
    chk("max_latency", 64'(n), 64'sd254);
    chk("max_data", 64'($signed(out_data)), 64'sd4194304);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        start = 1'b1; cfg_len = 9'd1;
      end
      tick();
      start = 1'b0;
      chk("bp_hold", 64'({out_valid, out_data}), 64'({1'b1, 32'd4194304}));
    end
    start = 1'b1; out_ready = 1'b1;
    tick(); start = 1'b0; out_ready = 1'b0;
    chk("bp_after_hs", 64'({busy, out_valid}), 64'sd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_no_rd", 64'({busy, rd_en}), 64'sd0);
    end

    // Zero-length run followed by back-to-back N=1: 7 * -3 = -21
    ifm_mem[5] = 8'd7; wgt_mem[6] = 8'hFD;
    cfg_len = 9'd0; cfg_ifm_base = 10'd5; cfg_wgt_base = 10'd6; start = 1'b1;
    tick();
    cfg_len = 9'd1; out_ready = 1'b1;
    chk("len0_out", 64'({out_valid, rd_en, out_data}), 64'({1'b1, 1'b0, 32'd0}));
    tick();
    chk("b2b_idle", 64'({busy, rd_en}), 64'sd0);
    tick(); start = 1'b0;
    chk("b2b_issue", 64'({busy, rd_en, ifm_addr, wgt_addr}), 64'({1'b1, 1'b1, 10'd5, 10'd6}));
    wait_valid(10, n);
    chk("b2b_latency", 64'(n), 64'sd3);
    chk("b2b_data", 64'($signed(out_data)), -64'sd21);
    tick(); out_ready = 1'b0;
    chk("b2b_after_hs", 64'(out_valid), 64'sd0);

    // Reset at idx 5 of N=10, then a fresh N=2 run: -8 + 15 = 7
    fill(8'h09, 8'h09);
    cfg_len = 9'd10; cfg_ifm_base = 10'd0; cfg_wgt_base = 10'd0; start = 1'b1;
    tick(); start = 1'b0;
    repeat (5) tick();
    chk("abort_idx5", 64'({rd_en, ifm_addr}), 64'({1'b1, 10'd5}));
    #2 rst_n = 1'b0;
    #1 chk_zero("midrst");
    tick(); rst_n = 1'b1;
    tick();
    ifm_mem[0] = 8'd2; ifm_mem[1] = 8'd3; wgt_mem[0] = 8'hFC; wgt_mem[1] = 8'd5;
    cfg_len = 9'd2; start = 1'b1;
    tick(); start = 1'b0;
    wait_valid(10, n);
    chk("fresh_latency", 64'(n), 64'sd4);
    chk("fresh_data", 64'($signed(out_data)), 64'sd7);
    out_ready = 1'b1;
    tick(); out_ready = 1'b0;
    chk("fresh_after_hs", 64'({busy, out_valid}), 64'sd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pe_mac_sequencer.md
# pe_mac_sequencer

Sequencer for one PE multiplier: streams a configured run of IFM/weight operand pairs from two synchronous-read buffers into the PE, tracks the PE's one-cycle registered latency, and accumulates the signed products into one dot-product result. The result is returned on a valid/ready port. Sits between the operand buffers and the output/post-processing stage; one instance per PE column.

## Interface
- INPUT_WIDTH, 8: signed operand width (IFM and weight).
- PRODUCT_WIDTH, 20: signed PE product width.
- ACC_WIDTH, 32: signed accumulator / result width.
- ADDR_WIDTH, 10: buffer address width.
- MAX_LEN, 256: maximum MACs per run; LEN_W = $clog2(MAX_LEN+1).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  reset: one clock; asynchronous, active-low.
- start  in  1  run request; sampled only in IDLE.
- cfg_len  in  LEN_W  MACs in run, 0..MAX_LEN; latched on start.
- cfg_ifm_base, cfg_wgt_base  in  ADDR_WIDTH  first buffer addresses; latched on start.
- busy  out  1  high in every state except IDLE.
- rd_en  out  1  buffer read strobe.
- ifm_addr, wgt_addr  out  ADDR_WIDTH  read addresses.
- ifm_data, wgt_data  in  INPUT_WIDTH  buffer read data, valid the cycle after rd_en.
- pe_ifm, pe_wgt  out  INPUT_WIDTH  PE operands (signed).
- pe_product  in  PRODUCT_WIDTH  PE registered product (1-cycle latency, resets to 0).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_data  out  ACC_WIDTH  signed dot-product result.

## Operation
- States: IDLE, ISSUE, DRAIN, OUT.
- IDLE: start=1 latches cfg, clears accumulator and index. Next state is ISSUE if cfg_len>0. If cfg_len=0, next state is OUT with out_data=0.
- ISSUE: rd_en=1, ifm_addr=ifm_base+idx, wgt_addr=wgt_base+idx. Sums wrap modulo 2^ADDR_WIDTH. idx increments each cycle. After the cycle with idx=len-1, go to DRAIN.
- Valid pipeline v1 = rd_en delayed 1 cycle; v2 = v1 delayed 1 cycle.
- pe_ifm/pe_wgt = ifm_data/wgt_data when v1, else 0. Idle PE cycles therefore produce 0.
- When v2=1, acc <= acc + sign-extended pe_product. Accumulation wraps two's complement; no saturation.
- The product accumulates exactly once per issued read.
- DRAIN: wait until v1=0 and v2=0 and the final add has landed, then go to OUT.
- OUT: out_valid=1 and out_data=acc, both held stable until out_valid&&out_ready. Then go to IDLE.
- start is ignored outside IDLE, including in the same cycle the OUT handshake completes.
- Width rule: PRODUCT_WIDTH+$clog2(MAX_LEN) ≤ ACC_WIDTH. Elaboration error otherwise.

## Timing
- Reset values: all outputs 0 (busy, rd_en, addresses, pe_ifm, pe_wgt, out_valid, out_data). State IDLE; acc, idx, v1, v2 all 0.
- start high in IDLE cycle C with len N>0: rd_en high cycles C+1..C+N; products valid C+3..C+N+2; out_valid rises in cycle C+N+3. busy high C+1 until the handshake cycle, inclusive.
- len=0: out_valid in cycle C+1, out_data=0, no rd_en.
- Earliest back-to-back: next start is accepted in the cycle after the handshake.
- Reset mid-run: immediate return to reset values. In-flight reads and products are discarded, and no out_valid is produced for that run.
- N=MAX_LEN: idx reaches MAX_LEN-1 without overflow; LEN_W holds MAX_LEN.

## Structure
- Package pe_mac_pkg: state enum (IDLE, ISSUE, DRAIN, OUT), default width localparams, and the width-check function.
- One sub-module, pe_mac_accum: v1/v2 valid pipeline, operand gating, sign-extending accumulator with clear.
- The top level holds the FSM, index and address generation, and the output register.

## Test plan
- Reset then idle: rst_n low mid-cycle → all outputs 0 asynchronously; no rd_en with start=0.
- N=3, IFM {1,-2,3}, WGT {4,5,-6}, bases 0/100: rd_en at C+1..C+3; addresses 0,1,2 and 100,101,102; out_data=-24 at C+6.
- Extremes: N=MAX_LEN, all IFM=-128, WGT=-128 → out_data=4194304; ifm_base=1020 wraps to address 0 at idx 4.
- Backpressure: out_ready low for 5 cycles → out_valid and out_data stable. A start pulse during OUT is ignored (no rd_en afterwards).
- cfg_len=0 → out_valid at C+1 with 0. Back-to-back run accepted the cycle after the handshake.
- Reset asserted at idx=5 of N=10 → outputs 0. A fresh N=2 run afterwards gives the correct sum with no residue from the aborted run.
